// File: rtl/adder_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte-index width; a 1-word build still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rca.sv
// 8-bit ripple-carry adder with exposed carry-in and carry-out.
module rca
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add/subtract: one rca pass per byte, LSB first,
// with the carry held in a register between passes.
module mp_add_seq
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int                W        = BYTE_W * WORDS;
    localparam int                IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic              ovf_q,   ovf_d;
    logic [W-1:0]      opa_q,   opa_d;
    logic [W-1:0]      opb_q,   opb_d;
    logic [W-1:0]      sum_q,   sum_d;

    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_sum;
    logic              byte_cout;

    assign byte_a = opa_q[idx_q*BYTE_W +: BYTE_W];
    assign byte_b = opb_q[idx_q*BYTE_W +: BYTE_W];

    rca u_rca (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (carry_q),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                    opa_d   = in_a;
                    opb_d   = in_sub ? ~in_b : in_b;
                    carry_d = in_sub | in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = byte_sum;
                carry_d = byte_cout;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) &&
                              (byte_sum[BYTE_W-1] != opa_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: operand and sum registers are reset along with control so every
    // output reads zero immediately after rst, including mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: a 4-byte and a 1-byte instance checked
// against an arithmetic model plus hand-computed directed results.
module tb_mp_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid4 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready4, out_valid4, out_cout4, out_ovf4, busy4;
    logic [31:0] out_sum4;
    logic        in_ready1, out_valid1, out_cout1, out_ovf1, busy1;
    logic [7:0]  out_sum1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    logic pv4 = 1'b0;
    logic pv1 = 1'b0;

    mp_add_seq #(.WORDS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_sum   (out_sum4),
        .out_cout  (out_cout4),
        .out_ovf   (out_ovf4),
        .busy      (busy4)
    );

    mp_add_seq #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a[7:0]),
        .in_b      (in_b[7:0]),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_sum   (out_sum1),
        .out_cout  (out_cout1),
        .out_ovf   (out_ovf1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry and true signed range check.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t            e;
        longint unsigned ua, ub, mask, r;
        longint          sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        lim  = longint'(64'd1 << (w - 1));
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        if (sub) begin
            r      = (ua - ub) & mask;
            e.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            r = ua + ub;
            sr = sa + sb;
            if (cin) begin
                r  = r + 64'd1;
                sr = sr + 1;
            end
            e.cout = ((r >> w) != 0);
            r      = r & mask;
        end
        e.sum = r[31:0];
        e.ovf = (sr >= lim) || (sr < -lim);
        e.acc = acc;
        return e;
    endfunction

    // Scoreboard: push expectations on accept, pop on drain.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q4.delete();
            q1.delete();
        end else begin
            if (out_valid4 && out_ready && q4.size() > 0) void'(q4.pop_front());
            if (out_valid1 && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (in_valid4 && in_ready4) q4.push_back(model(32, in_a, in_b, in_cin, in_sub, cyc + 1));
            if (in_valid1 && in_ready1) q1.push_back(model(8, in_a, in_b, in_cin, in_sub, cyc + 1));
        end
    end

    // Compare every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst && out_valid4) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected_result", 64'd1, 64'd0);
            end else begin
                check("sum4", out_sum4, q4[0].sum);
                check("cout4", out_cout4, q4[0].cout);
                check("ovf4", out_ovf4, q4[0].ovf);
                check("in_ready4_done", in_ready4, 1'b0);
                check("busy4_done", busy4, 1'b1);
                if (!pv4) check("lat4", cyc - q4[0].acc, 4);
            end
        end
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected_result", 64'd1, 64'd0);
            end else begin
                check("sum1", {24'd0, out_sum1}, q1[0].sum);
                check("cout1", out_cout1, q1[0].cout);
                check("ovf1", out_ovf1, q1[0].ovf);
                check("busy1_done", busy1, 1'b1);
                if (!pv1) check("lat1", cyc - q1[0].acc, 1);
            end
        end
        pv4 <= out_valid4;
        pv1 <= out_valid1;
    end

    // Caller is at a negedge with the target instance idle.
    task automatic run_op(input bit one, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input bit lit,
                          input logic [31:0] xs, input logic xc, input logic xo,
                          input int hold);
        int          guard;
        logic        rdy, vld;
        logic [31:0] s;
        logic        c, o;
        in_a   = a;
        in_b   = b;
        in_cin = cin;
        in_sub = sub;
        if (one) in_valid1 = 1'b1; else in_valid4 = 1'b1;
        rdy = one ? in_ready1 : in_ready4;
        check("accept_immediate", rdy, 1'b1);
        guard = 0;
        while (!(one ? in_ready1 : in_ready4) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        guard = 0;
        vld = 1'b0;
        while (!vld && guard < 50) begin
            @(negedge clk);
            vld = one ? out_valid1 : out_valid4;
            guard++;
        end
        if (!vld) begin
            check("result_timeout", 64'd0, 64'd1);
        end else begin
            s = one ? {24'd0, out_sum1} : out_sum4;
            c = one ? out_cout1 : out_cout4;
            o = one ? out_ovf1 : out_ovf4;
            if (lit) begin
                check("lit_sum", s, xs);
                check("lit_cout", c, xc);
                check("lit_ovf", o, xo);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_a      = ~a;
                in_b      = b ^ 32'h5A5A_5A5A;
                in_valid4 = ~in_valid4;
                check("bp_in_ready", in_ready4, 1'b0);
                check("bp_out_valid", out_valid4, 1'b1);
                check("bp_sum_stable", out_sum4, s);
            end
            in_valid4 = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("idle_after_drain", one ? in_ready1 : in_ready4, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready4,  1'b1);
        check({tag, "_out_valid"}, out_valid4, 1'b0);
        check({tag, "_out_sum"},   out_sum4,   32'd0);
        check({tag, "_out_cout"},  out_cout4,  1'b0);
        check({tag, "_out_ovf"},   out_ovf4,   1'b0);
        check({tag, "_busy"},      busy4,      1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset1_in_ready", in_ready1, 1'b1);
        check("reset1_out_sum", {24'd0, out_sum1}, 32'd0);
        rst = 1'b0;

        // Hand-computed directed vectors (WORDS=4).
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h0000_0000, 1, 0, 0);
        run_op(0, 32'h0000_0005, 32'h0000_0007, 0, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
        run_op(0, 32'h0000_0007, 32'h0000_0005, 0, 1, 1, 32'h0000_0002, 1, 0, 0);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h8000_0000, 0, 1, 0);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 0, 1, 1, 32'h7FFF_FFFF, 1, 1, 0);
        run_op(0, 32'h0000_0100, 32'h0000_0001, 0, 1, 1, 32'h0000_00FF, 1, 0, 0);
        run_op(0, 32'h0000_00FF, 32'h0000_0000, 1, 0, 1, 32'h0000_0100, 0, 0, 0);
        run_op(0, 32'h00FF_00FF, 32'h0001_0001, 0, 0, 1, 32'h0100_0100, 0, 0, 0);
        run_op(0, 32'h0000_0000, 32'h8000_0000, 0, 1, 1, 32'h8000_0000, 0, 1, 0);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h0000_0000, 1, 1, 0);
        // Subtract ignores in_cin.
        run_op(0, 32'h0000_000A, 32'h0000_0003, 1, 1, 1, 32'h0000_0007, 1, 0, 0);

        // Backpressure: 5 cycles stalled in DONE with in_valid pulses.
        run_op(0, 32'h89AB_CDEF, 32'h7654_3210, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 5);
        run_op(0, 32'h0000_0003, 32'h0000_0004, 0, 0, 1, 32'h0000_0007, 0, 0, 0);

        // Reset during RUN at idx=2.
        in_a      = 32'h1234_5678;
        in_b      = 32'h1111_1111;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_before_rst", busy4, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready4, 1'b1);
        run_op(0, 32'h1234_5678, 32'h1111_1111, 0, 0, 1, 32'h2345_6789, 0, 0, 0);

        // WORDS=1 instance.
        run_op(1, 32'h0000_00FF, 32'h0000_0001, 1, 0, 1, 32'h0000_0001, 1, 0, 0);
        run_op(1, 32'h0000_007F, 32'h0000_0001, 0, 0, 1, 32'h0000_0080, 0, 1, 0);
        run_op(1, 32'h0000_0003, 32'h0000_0005, 0, 1, 1, 32'h0000_00FE, 0, 0, 0);

        // Model-only vectors on both instances.
        for (int i = 0; i < 8; i++) begin
            run_op(i[0], $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 32'd0, 1'b0, 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Byte-serial multi-precision add/subtract sequencer built around the existing 8-bit ripple-carry adder `rca`. It accepts two WORDS-byte operands over a valid/ready handshake and steps them through a single `rca` instance one byte per cycle, least-significant byte first. The carry is registered between passes. It returns the full-width sum, the carry-out and a signed-overflow flag over a second valid/ready handshake. It sits between an operand producer and a result consumer wherever wide arithmetic is needed but only one 8-bit adder is available.

## Interface
- WORDS, default 4: operand width in bytes; legal range 1..16; data width W = 8*WORDS.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for add mode; ignored when in_sub=1.
- in_sub  in  1  1 = compute A - B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  result.
- out_cout  out  1  carry out of the MSB. In subtract mode this is the not-borrow: 1 when A >= B unsigned.
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one byte per cycle.
  - DONE: out_valid=1.
- IDLE, on in_valid=1:
  - Latch A into the operand register opA.
  - Latch B, or ~B when in_sub=1, into the operand register opB.
  - Set the carry register to in_cin, or to 1 when in_sub=1.
  - Clear the byte index to 0 and go to RUN.
- RUN, each cycle:
  - Drive `rca` with opA[idx], opB[idx] and the carry register.
  - Write the `rca` sum into byte idx of the sum register.
  - Load the carry register from the `rca` carry-out.
  - At idx=WORDS-1, go to DONE; otherwise increment idx.
- Overflow rule: out_ovf = (opA[W-1] == opB[W-1]) && (sum[W-1] != opA[W-1]). opB is the stored, already-inverted operand. out_ovf is registered on the last RUN cycle.
- DONE: out_sum, out_cout and out_ovf are held stable while out_valid=1. On out_ready=1, go to IDLE.
- in_ready is high only in IDLE. Inputs presented outside IDLE are ignored.
- Arithmetic is modulo 2^W. The carry propagates across byte boundaries only through the carry register; there is no combinational carry chain across bytes.

## Timing
- Reset values:
  - state=IDLE, idx=0, carry=0.
  - opA, opB and the sum register = 0.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
- Latency:
  - Operands are accepted at rising edge 0.
  - RUN occupies the cycles after edges 0..WORDS-1.
  - out_valid rises after edge WORDS, i.e. WORDS cycles after acceptance.
- Throughput:
  - Accept-to-accept is at least WORDS+2 cycles: WORDS RUN cycles, ≥1 DONE cycle, and 1 IDLE cycle.
  - There is no overlap between result drain and the next acceptance.
- Backpressure: with out_ready=0, DONE persists indefinitely with all outputs frozen.
- Reset mid-operation:
  - Asserting rst in any state returns to reset values immediately; the in-flight operation is discarded.
  - After rst deasserts, in_ready=1 in the first cycle.
- WORDS=1: a single RUN cycle; out_valid rises 1 cycle after acceptance.

## Structure
- Shared package `adder_pkg`:
  - State enum (IDLE, RUN, DONE).
  - Byte width constant BYTE_W=8.
  - Index width function $clog2(WORDS) (min 1).
- Sub-module: exactly one instance of the existing `rca`, connected with its carry-in and carry-out exposed. No other arithmetic on the datapath.
- Control FSM, index counter and registers live in mp_add_seq itself; no separate controller module.

## Test plan
- WORDS=4, add 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0; out_valid high exactly 4 cycles after the accept edge.
- Subtract 0x00000005 - 0x00000007 -> out_sum=0xFFFFFFFE, out_cout=0, out_ovf=0. Then 0x00000007 - 0x00000005 -> 0x00000002, out_cout=1.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, out_ovf=1, out_cout=0. Subtract 0x80000000 - 0x00000001 -> 0x7FFFFFFF, out_ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, and in_valid pulses are ignored.
  - Then out_ready=1: DONE->IDLE, and the next request is accepted one cycle later.
- Reset mid-operation:
  - Assert rst during RUN at idx=2: all outputs return to reset values asynchronously.
  - After release, the add 0x12345678 + 0x11111111 yields 0x23456789 with out_cout=0.
- WORDS=1 build: 0xFF + 0x01 with cin=1 -> out_sum=0x01, out_cout=1, out_valid 1 cycle after acceptance.
